// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: processor-side register bus of the UART controller.
//   CS_N    chip select, active low (from the address decoder)
//   RD_N    read strobe, active low
//   WR_N    write strobe, active low
//   Addr    byte address, only [4:2] decoded by the slave
//   DataIn  write data
//   DataOut read data (0 when not selected for read)
//   Intr    interrupt request, active high
interface uart_ctrl_if;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Intr;

  modport master (
    output CS_N, RD_N, WR_N, Addr, DataIn,
    input  DataOut, Intr
  );

  modport slave (
    input  CS_N, RD_N, WR_N, Addr, DataIn,
    output DataOut, Intr
  );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped 8N1 UART with a TX FIFO and a single-byte RX holding
// register.
//   clk    single clock, rising edge
//   reset  asynchronous, active high
//   bus    uart_ctrl_if.slave register bus (CS_N/RD_N/WR_N/Addr/DataIn/DataOut/Intr)
//   RXD    serial input, asynchronous to clk
//   TXD    serial output, idle high
// Register map (Addr[4:2]): 0x00 TXDATA, 0x04 RXDATA, 0x08 STATUS, 0x0C CTRL,
// 0x10 BAUDDIV; other offsets read 0 and ignore writes.
// Optional feature: define UART_LOOPBACK_EN to enable CTRL.loopback (RX fed
// from TXD); without it CTRL bit2 reads 0 and RX always comes from RXD.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high; pops the FIFO head when one is available
//   TX_START | start bit (low) for one bit period
//   TX_DATA  | 8 data bits, LSB first, one bit period each
//   TX_STOP  | stop bit (high) for one bit period
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised input
//   RX_START | half a period in, confirms the start bit or rejects a glitch
//   RX_DATA  | samples 8 data bits, one period apart
//   RX_STOP  | samples the stop bit and completes the frame
module uart_ctrl #(
  parameter int unsigned BAUD_DIV_RST = 434,
  parameter int unsigned TX_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  uart_ctrl_if.slave  bus,
  input  logic        RXD,
  output logic        TXD
);

  localparam int unsigned PW = $clog2(TX_DEPTH);

  localparam logic [2:0] A_TXDATA  = 3'd0;
  localparam logic [2:0] A_RXDATA  = 3'd1;
  localparam logic [2:0] A_STATUS  = 3'd2;
  localparam logic [2:0] A_CTRL    = 3'd3;
  localparam logic [2:0] A_BAUDDIV = 3'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        wr_en, rd_en;
  logic [2:0]  reg_sel;
  logic        tx_ie, rx_ie, loopback;
  logic [15:0] baud_div, period;

  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] fifo_cnt;
  logic        tx_full, tx_empty, fifo_push, tx_pop;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_timer, tx_timer_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        txd_q, txd_n, tx_busy;

  logic        rx_src, rx_sync1, rx_s, rx_prev;
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_timer, rx_timer_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic        rx_done_good, rx_done_bad, rx_pop;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun, frame_err;

  logic [31:0] rd_data, status;
  logic        unused_bits;

  assign wr_en   = ~bus.CS_N & ~bus.WR_N;
  assign rd_en   = ~bus.CS_N & ~bus.RD_N;
  assign reg_sel = bus.Addr[4:2];
  assign unused_bits = ^{bus.Addr[11:5], bus.Addr[1:0], bus.DataIn[31:16]};

  // Divisors below 2 would leave no room for a mid-bit RX sample.
  assign period = (baud_div < 16'd2) ? 16'd2 : baud_div;

  // ---------------- configuration registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ie    <= 1'b0;
      rx_ie    <= 1'b0;
      baud_div <= 16'(BAUD_DIV_RST);
    end else if (wr_en) begin
      if (reg_sel == A_CTRL) begin
        tx_ie <= bus.DataIn[0];
        rx_ie <= bus.DataIn[1];
      end
      if (reg_sel == A_BAUDDIV) baud_div <= bus.DataIn[15:0];
    end
  end

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            loopback <= 1'b0;
    else if (wr_en && reg_sel == A_CTRL)  loopback <= bus.DataIn[2];
  end
  assign rx_src = loopback ? txd_q : RXD;
`else
  assign loopback = 1'b0;
  assign rx_src   = RXD;
`endif

  // ---------------- TX FIFO ----------------
  assign tx_full   = (fifo_cnt == (PW+1)'(TX_DEPTH));
  assign tx_empty  = (fifo_cnt == '0);
  // Full is judged before the edge, so a write is dropped even if the FSM pops now.
  assign fifo_push = wr_en && (reg_sel == A_TXDATA) && !tx_full;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= bus.DataIn[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  // The bit timer reloads from the live divisor at each bit boundary, so a
  // BAUDDIV write only changes the next bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_timer <= tx_timer_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
      txd_q    <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_timer_n = tx_timer;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    txd_n      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr];
          tx_timer_n = period - 16'd1;
          txd_n      = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_timer != 16'd0) tx_timer_n = tx_timer - 16'd1;
        else begin
          tx_timer_n = period - 16'd1;
          tx_bit_n   = 3'd0;
          txd_n      = tx_shift[0];
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_timer != 16'd0) tx_timer_n = tx_timer - 16'd1;
        else begin
          tx_timer_n = period - 16'd1;
          if (tx_bit == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
            tx_bit_n   = tx_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_timer != 16'd0) tx_timer_n = tx_timer - 16'd1;
        else                   tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign TXD     = txd_q;
  assign tx_busy = (tx_state != TX_IDLE);

  // ---------------- RX synchroniser and FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_sync1 <= rx_src;
      rx_s     <= rx_sync1;
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_timer <= rx_timer_n;
      rx_shift <= rx_shift_n;
      rx_bit   <= rx_bit_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_timer_n   = rx_timer;
    rx_shift_n   = rx_shift;
    rx_bit_n     = rx_bit;
    rx_done_good = 1'b0;
    rx_done_bad  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_timer_n = {1'b0, period[15:1]} - 16'd1;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_timer != 16'd0) rx_timer_n = rx_timer - 16'd1;
        else if (rx_s)         rx_state_n = RX_IDLE;
        else begin
          rx_timer_n = period - 16'd1;
          rx_bit_n   = 3'd0;
          rx_state_n = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_timer != 16'd0) rx_timer_n = rx_timer - 16'd1;
        else begin
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_timer_n = period - 16'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_timer != 16'd0) rx_timer_n = rx_timer - 16'd1;
        else begin
          rx_state_n   = RX_IDLE;
          rx_done_good = rx_s;
          rx_done_bad  = ~rx_s;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX holding register and status flags ----------------
  assign rx_pop = wr_en && (reg_sel == A_RXDATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr_en && reg_sel == A_STATUS) begin
        if (bus.DataIn[3]) rx_overrun <= 1'b0;
        if (bus.DataIn[4]) frame_err  <= 1'b0;
      end
      if (rx_done_bad) frame_err <= 1'b1;
      // A pop on the completion edge frees the holder first.
      if (rx_done_good) begin
        if (rx_valid && !rx_pop) rx_overrun <= 1'b1;
        else begin
          rx_byte  <= rx_shift;
          rx_valid <= 1'b1;
        end
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // ---------------- read mux and interrupt ----------------
  assign status = {26'd0, tx_busy, frame_err, rx_overrun, rx_valid, tx_empty, tx_full};

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (reg_sel)
        A_RXDATA:  rd_data = {24'd0, rx_byte};
        A_STATUS:  rd_data = status;
        A_CTRL:    rd_data = {29'd0, loopback, rx_ie, tx_ie};
        A_BAUDDIV: rd_data = {16'd0, baud_div};
        default:   rd_data = '0;
      endcase
    end
  end

  assign bus.DataOut = rd_data;
  assign bus.Intr    = (tx_ie & tx_empty & ~tx_busy) | (rx_ie & rx_valid) | (rx_ie & rx_overrun);

endmodule

// File: tb/tb_uart_ctrl.sv
`timescale 1ns/1ps
module tb_uart_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic RXD;
  logic TXD;

  uart_ctrl_if bus();

  uart_ctrl #(.BAUD_DIV_RST(434), .TX_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .RXD   (RXD),
    .TXD   (TXD)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.CS_N = 1'b0; bus.WR_N = 1'b0; bus.Addr = a; bus.DataIn = d;
    @(negedge clk);
    bus.CS_N = 1'b1; bus.WR_N = 1'b1;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.CS_N = 1'b0; bus.RD_N = 1'b0; bus.Addr = a;
    #1 d = bus.DataOut;
    bus.CS_N = 1'b1; bus.RD_N = 1'b1;
  endtask

  task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  // Expects a full 8N1 frame of d at p clocks per bit, sampled every negedge.
  // first=1: wait (bounded) for the start bit; first=0: exactly one idle clock
  // must separate it from the previous frame.
  task automatic tx_expect(input logic [7:0] d, input int p, input bit first,
                           input string tag, output int waited);
    logic [9:0] bits;
    int errs;
    bits = {1'b1, d, 1'b0};
    errs = 0;
    waited = 0;
    if (first) begin
      @(negedge clk);
      while (TXD !== 1'b0 && waited < 20000) begin
        @(negedge clk);
        waited++;
      end
    end else begin
      @(negedge clk);
      if (TXD !== 1'b1) errs++;
      @(negedge clk);
    end
    for (int i = 0; i < 10 * p; i++) begin
      if (i > 0) @(negedge clk);
      if (TXD !== bits[i / p]) errs++;
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] d, input int p, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      RXD = f[k];
      repeat (p - 1) @(negedge clk);
    end
    @(negedge clk);
    RXD = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (TXD === 1'b0) lows++;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  bytes [9];
    int          w, n, b, p, lows;
    logic [7:0]  m_byte;
    bit          m_valid, m_ovr, do_pop;

    reset = 1'b1;
    RXD = 1'b1;
    bus.CS_N = 1'b1; bus.RD_N = 1'b1; bus.WR_N = 1'b1;
    bus.Addr = '0; bus.DataIn = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state and decode
    check_reg("rst STATUS", 12'h008, 32'h02);
    check_reg("rst CTRL", 12'h00C, 32'h0);
    check_reg("rst BAUDDIV", 12'h010, 32'd434);
    check_reg("rst RXDATA", 12'h004, 32'h0);
    check_reg("TXDATA reads 0", 12'h000, 32'h0);
    check_reg("unmapped 0x14", 12'h014, 32'h0);
    check_reg("alias 0x108", 12'h108, 32'h02);
    check("rst TXD", 32'(TXD), 32'd1);
    check("rst Intr", 32'(bus.Intr), 32'd0);
    bus_write(12'h014, 32'hFFFF_FFFF);
    check_reg("unmapped write ignored", 12'h010, 32'd434);

    bus_write(12'h00C, 32'h1);
    check("tx idle Intr", 32'(bus.Intr), 32'd1);
    bus_write(12'h00C, 32'h7);
`ifdef UART_LOOPBACK_EN
    check_reg("CTRL rw", 12'h00C, 32'h7);
`else
    check_reg("CTRL rw", 12'h00C, 32'h3);
`endif
    bus_write(12'h00C, 32'h0);

    // exact waveform of 0xA5 at 4 clocks per bit
    bus_write(12'h010, 32'd4);
    check_reg("BAUDDIV rw", 12'h010, 32'd4);
    bus_write(12'h000, 32'hA5);
    tx_expect(8'hA5, 4, 1'b1, "tx A5 frame", w);
    check("tx A5 latency", 32'(w), 32'd0);
    check_reg("tx A5 done STATUS", 12'h008, 32'h02);

    // random bursts at random divisors, including 0 and 1 which clamp to 2
    for (int r = 0; r < 4; r++) begin
      b = (r == 0) ? 0 : $urandom_range(1, 6);
      p = (b < 2) ? 2 : b;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) bytes[i] = 8'($urandom);
      bus_write(12'h010, 32'(b));
      fork
        begin
          for (int i = 0; i < n; i++) bus_write(12'h000, {24'd0, bytes[i]});
        end
        begin
          for (int i = 0; i < n; i++)
            tx_expect(bytes[i], p, (i == 0), $sformatf("tx rnd r%0d b%0d", r, i), w);
        end
      join
      check_reg($sformatf("tx rnd r%0d idle", r), 12'h008, 32'h02);
    end

    // FIFO full: one byte keeps the FSM busy, 8 fill the FIFO, the 9th is dropped
    bus_write(12'h010, 32'd100);
    for (int i = 0; i < 9; i++) bytes[i] = 8'($urandom);
    fork
      begin
        bus_write(12'h000, 32'h11);
        for (int i = 0; i < 9; i++) begin
          bus_write(12'h000, {24'd0, bytes[i]});
          if (i == 6) check_reg("fifo 7 not full", 12'h008, 32'h20);
          if (i == 7) check_reg("fifo 8 full", 12'h008, 32'h21);
        end
      end
      begin
        tx_expect(8'h11, 100, 1'b1, "fifo primer", w);
        for (int i = 0; i < 8; i++)
          tx_expect(bytes[i], 100, 1'b0, $sformatf("fifo byte %0d", i), w);
        count_low(1200, lows);
        check("fifo 9th dropped", 32'(lows), 32'd0);
      end
    join

    // RX: valid, overrun, clears
    bus_write(12'h010, 32'd8);
    bus_write(12'h00C, 32'h2);
    send_rx(8'h3C, 8, 1'b1);
    check_reg("rx 3C STATUS", 12'h008, 32'h06);
    check("rx valid Intr", 32'(bus.Intr), 32'd1);
    check_reg("rx 3C data", 12'h004, 32'h3C);
    send_rx(8'hC3, 8, 1'b1);
    check_reg("rx overrun STATUS", 12'h008, 32'h0E);
    check_reg("rx overrun keeps", 12'h004, 32'h3C);
    bus_write(12'h008, 32'h08);
    check_reg("rx overrun clr", 12'h008, 32'h06);
    bus_write(12'h004, 32'h0);
    check_reg("rx pop", 12'h008, 32'h02);
    check("rx pop Intr", 32'(bus.Intr), 32'd0);

    // framing error
    send_rx(8'h55, 8, 1'b0);
    check_reg("frame err STATUS", 12'h008, 32'h12);
    bus_write(12'h008, 32'h10);
    check_reg("frame err clr", 12'h008, 32'h02);

    // 2-clock glitch is rejected, receiver still works afterwards
    @(negedge clk); RXD = 1'b0;
    repeat (2) @(negedge clk);
    RXD = 1'b1;
    repeat (100) @(negedge clk);
    check_reg("glitch STATUS", 12'h008, 32'h02);
    send_rx(8'hA7, 8, 1'b1);
    check_reg("post glitch data", 12'h004, 32'hA7);
    bus_write(12'h004, 32'h0);

    // random RX against a one-byte holding model
    m_valid = 1'b0; m_ovr = 1'b0; m_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(2, 12);
      v = 32'($urandom);
      bus_write(12'h010, 32'(p));
      send_rx(v[7:0], p, 1'b1);
      if (m_valid) m_ovr = 1'b1;
      else begin m_valid = 1'b1; m_byte = v[7:0]; end
      bus_read(12'h008, v);
      check($sformatf("rx rnd %0d flags", i), {30'd0, v[3:2]}, {30'd0, m_ovr, m_valid});
      check_reg($sformatf("rx rnd %0d data", i), 12'h004, {24'd0, m_byte});
      do_pop = ($urandom_range(0, 1) == 1);
      if (do_pop) begin
        bus_write(12'h004, 32'h0);
        m_valid = 1'b0;
      end
    end
    bus_write(12'h008, 32'h18);
    bus_write(12'h004, 32'h0);
    check_reg("rx rnd cleared", 12'h008, 32'h02);

`ifdef UART_LOOPBACK_EN
    bus_write(12'h010, 32'd8);
    bus_write(12'h00C, 32'h4);
    bus_write(12'h000, 32'h5A);
    repeat (120) @(negedge clk);
    check_reg("loopback data", 12'h004, 32'h5A);
    bus_write(12'h004, 32'h0);
    bus_write(12'h00C, 32'h0);
`endif

    // asynchronous reset in the middle of a frame
    bus_write(12'h010, 32'd8);
    bus_write(12'h00C, 32'h3);
    bus_write(12'h000, 32'h00);
    repeat (40) @(negedge clk);
    check("mid frame TXD low", 32'(TXD), 32'd0);
    #1 reset = 1'b1;
    #1 check("async rst TXD", 32'(TXD), 32'd1);
    check("async rst Intr", 32'(bus.Intr), 32'd0);
    bus.CS_N = 1'b0; bus.RD_N = 1'b0; bus.Addr = 12'h008;
    #1 check("async rst STATUS", bus.DataOut, 32'h02);
    bus.Addr = 12'h00C;
    #1 check("async rst CTRL", bus.DataOut, 32'h0);
    bus.CS_N = 1'b1; bus.RD_N = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_low(200, lows);
    check("no frame after rst", 32'(lows), 32'd0);
    check_reg("BAUDDIV after rst", 12'h010, 32'd434);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
